mips32_prefetch: RTL and testbench



---
 rtl/mips32_prefetch.sv | 143 ++++++++++++++
 tb/tb_mips32_prefetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prefetch.sv
// mips32_prefetch: instruction prefetch buffer in front of the IF stage.
// Ports: clk1/rst_n, imem_* request/response, redirect/halt, if_* head.
module mips32_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          if_valid,
  output logic [31:0]   if_ir,
  output logic [31:0]   if_npc,
  input  logic          if_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   ir_q  [DEPTH];
  logic [31:0]   ir_d  [DEPTH];
  logic [31:0]   npc_q [DEPTH];
  logic [31:0]   npc_d [DEPTH];
  logic [31:0]   tag_q [DEPTH];
  logic [31:0]   tag_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0]   used;
  logic          accept;
  logic          dropping;
  logic          write;
  logic          pop;

  // Credits cover both buffered words and words still owed by memory,
  // so every accepted request has a FIFO slot waiting for it.
  assign used = {1'b0, count_q} + {1'b0, outst_q};

  assign imem_req  = rst_n & ~halt & ~redirect & (used < LIMIT);
  assign imem_addr = fetch_pc_q[AW-1:0];

  assign if_valid = (count_q != '0);
  assign if_ir    = ir_q[rd_ptr_q];
  assign if_npc   = npc_q[rd_ptr_q];

  assign accept   = imem_req & imem_ready;
  assign dropping = imem_rvalid & (drop_q != '0);
  assign write    = imem_rvalid & ~dropping & ~redirect;
  assign pop      = if_valid & if_ready & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    npc_d      = npc_q;
    tag_d      = tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    count_d    = count_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
    drop_d     = drop_q - CW'(dropping);

    if (accept) begin
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_wr_q + 1'b1;
      fetch_pc_d      = fetch_pc_q + 32'd1;
    end

    // Tags retire with every response, dropped or not.
    if (imem_rvalid) begin
      tag_rd_d = tag_rd_q + 1'b1;
    end

    if (write) begin
      ir_d[wr_ptr_q]  = imem_rdata;
      npc_d[wr_ptr_q] = tag_q[tag_rd_q] + 32'd1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q + CW'(write) - CW'(pop);

    // Redirect wins: everything still owed after this cycle is stale.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= ir_d[i];
        npc_q[i] <= npc_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mips32_prefetch.sv
// tb_mips32_prefetch: directed bench for mips32_prefetch.
// Drives a latency-configurable in-order memory model.
module tb_mips32_prefetch;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        if_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int acc_cnt = 0;

  logic [31:0] mem [1024];

  typedef struct {
    logic [9:0] a;
    int         due;
  } rsp_t;
  rsp_t q[$];

  mips32_prefetch #(
    .DEPTH(4), .AW(10), .RESET_PC(32'd0)
  ) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt),
    .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc),
    .if_ready(if_ready)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Memory: a request seen during cycle n answers during cycle n+lat.
  always @(negedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      imem_rvalid = 1'b0;
      acc_cnt = 0;
    end else begin
      imem_rvalid = 1'b0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem[q[0].a];
        void'(q.pop_front());
      end
      if (imem_req && imem_ready) begin
        q.push_back('{imem_addr, cyc + lat});
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at cycle 0 with reset released.
  task automatic reset_release();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;

    // Reset state
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ir", if_ir, 32'd0);
    chk("rst_npc", if_npc, 32'd0);
    chk("rst_addr", {22'd0, imem_addr}, 32'd0);

    // Streaming with 1-cycle memory
    lat = 1;
    if_ready = 1'b1;
    reset_release();
    #1;
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", {22'd0, imem_addr}, 32'd0);
    tick();
    chk("t1_valid_c1", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t1_valid_c2", {31'd0, if_valid}, 32'd1);
    chk("t1_ir0", if_ir, 32'h11);
    chk("t1_npc0", if_npc, 32'd1);
    tick();
    chk("t1_ir1", if_ir, 32'h22);
    chk("t1_npc1", if_npc, 32'd2);
    tick();
    chk("t1_ir2", if_ir, 32'h33);
    chk("t1_npc2", if_npc, 32'd3);
    tick();
    chk("t1_ir3", if_ir, 32'h44);
    chk("t1_npc3", if_npc, 32'd4);

    // Fill with IF stalled, asynchronous mid-run reset
    if_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t2_async_valid", {31'd0, if_valid}, 32'd0);
    chk("t2_async_req", {31'd0, imem_req}, 32'd0);
    reset_release();
    repeat (7) tick();
    chk("t2_accepts", acc_cnt, 32'd4);
    chk("t2_req_full", {31'd0, imem_req}, 32'd0);
    chk("t2_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_ir0", if_ir, 32'h11);
    if_ready = 1'b1;
    tick();
    chk("t2_ir1", if_ir, 32'h22);
    chk("t2_req_resume", {31'd0, imem_req}, 32'd1);
    chk("t2_addr4", {22'd0, imem_addr}, 32'd4);
    tick();
    chk("t2_ir2", if_ir, 32'h33);
    tick();
    chk("t2_ir3", if_ir, 32'h44);
    tick();
    chk("t2_ir4", if_ir, 32'hC0DE_0004);
    chk("t2_npc4", if_npc, 32'd5);

    // Redirect with 3-cycle memory and stale responses
    lat = 3;
    reset_release();
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("t3_req_redir", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_req_new", {31'd0, imem_req}, 32'd1);
    chk("t3_addr_new", {22'd0, imem_addr}, 32'h40);
    chk("t3_valid_r1", {31'd0, if_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("t3_valid_c7", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t3_valid_c8", {31'd0, if_valid}, 32'd1);
    chk("t3_ir", if_ir, 32'hC0DE_0040);
    chk("t3_npc", if_npc, 32'h41);

    // Redirect colliding with a response and a pop
    tick();
    chk("t4_ir_pre", if_ir, 32'hC0DE_0041);
    chk("t4_valid_pre", {31'd0, if_valid}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_valid_post", {31'd0, if_valid}, 32'd0);
    chk("t4_addr", {22'd0, imem_addr}, 32'h100);
    tick();
    tick();
    tick();
    chk("t4_valid_c13", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t4_ir", if_ir, 32'hC0DE_0100);
    chk("t4_npc", if_npc, 32'h101);

    // Halt with two requests in flight
    lat = 3;
    reset_release();
    tick();
    tick();
    halt = 1'b1;
    #1;
    chk("t5_req_halt", {31'd0, imem_req}, 32'd0);
    tick();
    chk("t5_valid_c3", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t5_ir0", if_ir, 32'h11);
    chk("t5_npc0", if_npc, 32'd1);
    tick();
    chk("t5_ir1", if_ir, 32'h22);
    chk("t5_npc1", if_npc, 32'd2);
    tick();
    chk("t5_valid_empty", {31'd0, if_valid}, 32'd0);
    chk("t5_accepts", acc_cnt, 32'd2);
    tick();
    chk("t5_valid_stay", {31'd0, if_valid}, 32'd0);
    chk("t5_req_stay", {31'd0, imem_req}, 32'd0);

    // Address and next-PC wrap
    lat = 1;
    halt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h3FF;
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr_3ff", {22'd0, imem_addr}, 32'h3FF);
    tick();
    chk("t6_addr_wrap", {22'd0, imem_addr}, 32'h000);
    tick();
    chk("t6_ir_3ff", if_ir, 32'hC0DE_03FF);
    chk("t6_npc_400", if_npc, 32'h400);
    tick();
    chk("t6_ir_0", if_ir, 32'h11);
    chk("t6_npc_401", if_npc, 32'h401);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_addr_max", {22'd0, imem_addr}, 32'h3FF);
    tick();
    tick();
    chk("t6_ir_max", if_ir, 32'hC0DE_03FF);
    chk("t6_npc_wrap", if_npc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
